// File: rtl/uart_receive_if.sv
// Serial receive bundle: the raw line into the receiver, and the byte/strobe/error results out of it.
interface uart_receive_if;
    logic       rx_wire_in;
    logic       new_data_out;
    logic [7:0] data_byte_out;
    logic       framing_error_out;

    modport master (
        output rx_wire_in,
        input  new_data_out,
        input  data_byte_out,
        input  framing_error_out
    );

    modport slave (
        input  rx_wire_in,
        output new_data_out,
        output data_byte_out,
        output framing_error_out
    );
endinterface

// File: rtl/uart_receive.sv
// 8N1 UART receiver sampling mid-bit; byte strobe appears 1 cycle after the mid-stop-bit sample.
// No backpressure: each result is a single-cycle pulse that the consumer must catch.
module uart_receive #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 115_200
) (
    input  logic          clk_100mhz,
    input  logic          sys_rst,
    uart_receive_if.slave rx_if
);
    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD     = BAUD_BIT_PERIOD / 2;
    localparam int CNT_W           = $clog2(BAUD_BIT_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BAUD_BIT_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_TRANSMIT
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic [1:0]       r_warm;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_new_data;
    logic             r_frame_err;
    logic             w_rx;
    logic             w_fall;

    // The synchronizer and history flop hold fake 1s for a few cycles after reset,
    // so edges are only trusted once r_rx_prev carries a real line sample.
    assign w_rx   = r_sync2;
    assign w_fall = (r_warm == 2'd3) && r_rx_prev && !w_rx;

    assign rx_if.new_data_out      = r_new_data;
    assign rx_if.data_byte_out     = r_data;
    assign rx_if.framing_error_out = r_frame_err;

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_warm      <= 2'd0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_new_data  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx_if.rx_wire_in;
            r_sync2     <= r_sync1;
            r_rx_prev   <= r_sync2;
            r_new_data  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_BIT_LAST) begin
                        r_shift[r_bit_idx] <= w_rx;
                        r_cnt              <= '0;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_BIT_LAST) begin
                        r_cnt <= '0;
                        // Outputs are set here so they are visible during the TRANSMIT cycle itself.
                        if (w_rx) begin
                            r_state    <= S_TRANSMIT;
                            r_data     <= r_shift;
                            r_new_data <= 1'b1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_TRANSMIT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive at default parameters (868 clocks per bit).
module tb_uart_receive;
    localparam int BIT = 868;
    // Line driven low at negedge c: 2 sync flops + edge cycle, 434 to mid-start,
    // 9*868 to mid-stop, +1 to the registered strobe -> strobe seen at negedge c+8249.
    localparam int LAT = 8249;

    logic clk_100mhz;
    logic sys_rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   n_new;
    int   n_fe;
    int   n_both;
    int   t_low;
    int   pulse_cyc[$];
    logic [7:0] pulse_dat[$];

    uart_receive_if bus ();

    uart_receive dut (
        .clk_100mhz (clk_100mhz),
        .sys_rst    (sys_rst),
        .rx_if      (bus)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    initial cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    initial begin
        n_new  = 0;
        n_fe   = 0;
        n_both = 0;
    end

    always @(negedge clk_100mhz) begin
        if (bus.new_data_out === 1'b1) begin
            n_new++;
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(bus.data_byte_out);
        end
        if (bus.framing_error_out === 1'b1) n_fe++;
        if (bus.new_data_out === 1'b1 && bus.framing_error_out === 1'b1) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100mhz);
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx_wire_in = bits[i];
            if (i == 0) t_low = cyc;
            repeat (per) @(negedge clk_100mhz);
        end
    endtask

    initial begin
        int base_new;
        int base_fe;
        int t0;
        n_cmp = 0;
        n_bad = 0;
        t_low = 0;
        sys_rst = 1'b1;
        bus.rx_wire_in = 1'b1;
        idle(5);
        check("rst_new_data", 32'(bus.new_data_out), 32'd0);
        check("rst_frame_err", 32'(bus.framing_error_out), 32'd0);
        check("rst_data_byte", 32'(bus.data_byte_out), 32'h00);

        // Line held low across reset release must not start a reception.
        bus.rx_wire_in = 1'b0;
        idle(5);
        sys_rst = 1'b0;
        idle(600);
        check("held_low_new", 32'(n_new), 32'd0);
        check("held_low_fe", 32'(n_fe), 32'd0);
        bus.rx_wire_in = 1'b1;
        idle(300);

        // 0x55 with exact strobe latency.
        base_new = n_new;
        base_fe  = n_fe;
        send_frame(8'h55, BIT, 1'b1);
        idle(200);
        check("f55_count", 32'(n_new - base_new), 32'd1);
        check("f55_data", 32'(bus.data_byte_out), 32'h55);
        check("f55_fe", 32'(n_fe - base_fe), 32'd0);
        if (pulse_cyc.size() > base_new)
            check("f55_latency", 32'(pulse_cyc[base_new] - t_low), 32'(LAT));
        else
            check("f55_latency_missing", 32'(pulse_cyc.size()), 32'(base_new + 1));

        // 200-cycle low glitch is rejected at the mid-start sample.
        base_new = n_new;
        base_fe  = n_fe;
        bus.rx_wire_in = 1'b0;
        idle(200);
        bus.rx_wire_in = 1'b1;
        idle(1200);
        check("glitch_new", 32'(n_new - base_new), 32'd0);
        check("glitch_fe", 32'(n_fe - base_fe), 32'd0);
        check("glitch_data", 32'(bus.data_byte_out), 32'h55);

        // 0xA3 with low stop bit, line then held low as a break.
        base_new = n_new;
        base_fe  = n_fe;
        send_frame(8'hA3, BIT, 1'b0);
        idle(1000);
        bus.rx_wire_in = 1'b1;
        idle(300);
        check("ferr_fe", 32'(n_fe - base_fe), 32'd1);
        check("ferr_new", 32'(n_new - base_new), 32'd0);
        check("ferr_data", 32'(bus.data_byte_out), 32'h55);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        base_new = n_new;
        send_frame(8'h00, BIT, 1'b1);
        send_frame(8'hFF, BIT, 1'b1);
        idle(200);
        check("b2b_count", 32'(n_new - base_new), 32'd2);
        if (pulse_cyc.size() >= base_new + 2) begin
            check("b2b_first", 32'(pulse_dat[base_new]), 32'h00);
            check("b2b_second", 32'(pulse_dat[base_new + 1]), 32'hFF);
            check("b2b_spacing", 32'(pulse_cyc[base_new + 1] - pulse_cyc[base_new]), 32'(10 * BIT));
        end else begin
            check("b2b_pulses_missing", 32'(pulse_cyc.size()), 32'(base_new + 2));
        end

        // Reset raised mid bit 4 of 0x3C and held past the end of that frame.
        base_new = n_new;
        base_fe  = n_fe;
        fork
            send_frame(8'h3C, BIT, 1'b1);
            begin
                idle(5 * BIT + BIT / 2);
                sys_rst = 1'b1;
                idle(5 * BIT);
                sys_rst = 1'b0;
            end
        join
        idle(300);
        check("rst_mid_new", 32'(n_new - base_new), 32'd0);
        check("rst_mid_fe", 32'(n_fe - base_fe), 32'd0);
        check("rst_mid_data", 32'(bus.data_byte_out), 32'h00);

        base_new = n_new;
        send_frame(8'h81, BIT, 1'b1);
        idle(200);
        check("f81_count", 32'(n_new - base_new), 32'd1);
        check("f81_data", 32'(bus.data_byte_out), 32'h81);

        // 0x5A at -3% and +3% bit time.
        base_new = n_new;
        base_fe  = n_fe;
        send_frame(8'h5A, 842, 1'b1);
        idle(200);
        check("skew_fast_data", 32'(bus.data_byte_out), 32'h5A);
        bus.rx_wire_in = 1'b1;
        t0 = n_new;
        send_frame(8'h5A, 894, 1'b1);
        idle(200);
        check("skew_slow_new", 32'(n_new - t0), 32'd1);
        check("skew_slow_data", 32'(bus.data_byte_out), 32'h5A);
        check("skew_fe", 32'(n_fe - base_fe), 32'd0);
        check("skew_total_new", 32'(n_new - base_new), 32'd2);

        check("never_both_high", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
